// File: rtl/csa_wide_add_seq.sv
// Word-serial WORDS*W-bit adder sequencer driving one external W-bit adder, LSW first.
// Optional subtract mode (in_sub port) is enabled by defining CSA_WIDE_SUB_EN.
module csa_wide_add_seq #(
    parameter int W     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W*WORDS-1:0]   in_a,
    input  logic [W*WORDS-1:0]   in_b,
    input  logic                 in_cin,
`ifdef CSA_WIDE_SUB_EN
    input  logic                 in_sub,
`endif
    output logic [W-1:0]         adder_a,
    output logic [W-1:0]         adder_b,
    output logic                 adder_cin,
    input  logic [W-1:0]         adder_sum,
    input  logic                 adder_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 out_of,
    output logic                 busy
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WORDS-1:0][W-1:0] a_q;
    logic [WORDS-1:0][W-1:0] b_q;     // holds Beff, so overflow uses the effective operand
    logic [WORDS-1:0][W-1:0] sum_q;
    logic [IW-1:0]           idx_q;
    logic                    carry_q;
    logic                    cout_q;
    logic                    of_q;

    logic [W*WORDS-1:0]      b_eff_in;
    logic                    cin_eff_in;

`ifdef CSA_WIDE_SUB_EN
    // Subtraction is A + ~B + 1; in_cin is ignored in that mode.
    assign b_eff_in   = in_sub ? ~in_b : in_b;
    assign cin_eff_in = in_sub ? 1'b1 : in_cin;
`else
    assign b_eff_in   = in_b;
    assign cin_eff_in = in_cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)        state_d = RUN;
            RUN:  if (idx_q == LAST)   state_d = DONE;
            DONE: if (out_ready)       state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign adder_a   = busy ? a_q[idx_q] : '0;
    assign adder_b   = busy ? b_q[idx_q] : '0;
    assign adder_cin = busy ? carry_q    : 1'b0;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_of    = of_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= b_eff_in;
                        carry_q <= cin_eff_in;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        of_q    <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= adder_sum;
                    carry_q      <= adder_cout;
                    if (idx_q == LAST) begin
                        idx_q  <= '0;
                        cout_q <= adder_cout;
                        of_q   <= (a_q[LAST][W-1] == b_q[LAST][W-1]) &&
                                  (adder_sum[W-1] != a_q[LAST][W-1]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
